// File: rtl/rbz_spi_loader.sv
// rbz_spi_loader: serialises one parallel write (up to 64 bits, MSB first)
// onto either the vector or the register SPI port of raybox-zero.
//
// Ports:
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_valid / o_ready         request handshake (accept when both high)
//   i_target                  0 = vector port, 1 = register port
//   i_len                     bit count, 0 means 64
//   i_data                    right-aligned payload, bit i_len-1 sent first
//   o_vec_csb/sclk/mosi       vector SPI port
//   o_reg_csb/sclk/mosi       register SPI port
//   o_busy                    transaction in progress
//   o_done                    one-cycle pulse when CSB deasserts
module rbz_spi_loader #(
  parameter int unsigned HALF_DIV = 2,
  parameter int unsigned GAP      = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_target,
  input  logic [5:0]  i_len,
  input  logic [63:0] i_data,
  output logic        o_vec_csb,
  output logic        o_vec_sclk,
  output logic        o_vec_mosi,
  output logic        o_reg_csb,
  output logic        o_reg_sclk,
  output logic        o_reg_mosi,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [7:0] DIV_HALF = 8'(HALF_DIV - 1);
  localparam logic [7:0] DIV_GAP  = 8'(GAP - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [6:0]  bits_q, bits_d;
  logic [63:0] shreg_q, shreg_d;
  logic        sel_q, sel_d;

  logic        accept_c;
  logic        active_c;
  logic        div_last_c;
  logic [6:0]  n_c;
  logic        ready_d, busy_d, done_d;
  logic        vec_csb_d, vec_sclk_d, vec_mosi_d;
  logic        reg_csb_d, reg_sclk_d, reg_mosi_d;

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bits_d   = bits_q;
    shreg_d  = shreg_q;
    sel_d    = sel_q;
    accept_c = i_valid && o_ready;
    div_last_c = (div_q == 8'd0);
    n_c      = (i_len == 6'd0) ? 7'd64 : {1'b0, i_len};

    if (state_q != S_IDLE && !div_last_c) begin
      div_d = div_q - 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          // Left-justify so the first bit sits in the MSB
          shreg_d = i_data << (7'd64 - n_c);
          bits_d  = n_c;
          sel_d   = i_target;
          div_d   = DIV_HALF;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (div_last_c) begin
          div_d   = DIV_HALF;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (div_last_c) begin
          div_d  = DIV_HALF;
          bits_d = bits_q - 7'd1;
          if (bits_q == 7'd1) begin
            state_d = S_HOLD;          // last bit stays on MOSI through HOLD
          end else begin
            shreg_d = {shreg_q[62:0], 1'b0};
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (div_last_c) begin
          div_d   = DIV_HALF;
          state_d = S_HI;
        end
      end
      S_HOLD: begin
        if (div_last_c) begin
          div_d   = DIV_GAP;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (div_last_c) begin
          div_d   = 8'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        div_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase

    active_c = (state_d == S_SETUP) || (state_d == S_HI) ||
               (state_d == S_LO)    || (state_d == S_HOLD);

    // Ready lags IDLE entry by one cycle and drops on the accept edge
    ready_d = (state_q == S_IDLE) && !accept_c;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_HOLD) && (state_d == S_GAP);

    vec_csb_d  = !(active_c && !sel_d);
    vec_sclk_d = (state_d == S_HI) && !sel_d;
    vec_mosi_d = active_c && !sel_d && shreg_d[63];
    reg_csb_d  = !(active_c && sel_d);
    reg_sclk_d = (state_d == S_HI) && sel_d;
    reg_mosi_d = active_c && sel_d && shreg_d[63];
  end

  // State, datapath and output registers
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      div_q      <= 8'd0;
      bits_q     <= 7'd0;
      shreg_q    <= 64'd0;
      sel_q      <= 1'b0;
      o_ready    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_vec_csb  <= 1'b1;
      o_vec_sclk <= 1'b0;
      o_vec_mosi <= 1'b0;
      o_reg_csb  <= 1'b1;
      o_reg_sclk <= 1'b0;
      o_reg_mosi <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bits_q     <= bits_d;
      shreg_q    <= shreg_d;
      sel_q      <= sel_d;
      o_ready    <= ready_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
      o_vec_csb  <= vec_csb_d;
      o_vec_sclk <= vec_sclk_d;
      o_vec_mosi <= vec_mosi_d;
      o_reg_csb  <= reg_csb_d;
      o_reg_sclk <= reg_sclk_d;
      o_reg_mosi <= reg_mosi_d;
    end
  end

endmodule

// File: doc/rbz_spi_loader.md
RBZ_SPI_LOADER -- requirements
Module: rbz_spi_loader

Purpose: SPI controller stage directly upstream of the raybox-zero top. It serialises parallel register/vector writes from the caravel-side host logic (LA/wishbone glue) onto the vector SPI port (vec_csb/sclk/mosi) and the register SPI port (reg_csb/sclk/mosi).

Interface
REQ-001 Parameter HALF_DIV, default 2: clocks per SCLK half-period; legal range 1..255.
REQ-002 Parameter GAP, default 4: clocks with CSB high after a transaction before o_ready reasserts; legal range 1..255.
REQ-003 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 i_reset_n  in  1  reset, synchronous, active-low.
REQ-005 i_valid  in  1  request strobe.
REQ-006 o_ready  out  1  request can be accepted this cycle.
REQ-007 i_target  in  1  port select: 0=vec, 1=reg.
REQ-008 i_len  in  6  bit count; 0 means 64.
REQ-009 i_data  in  64  payload, right-aligned; bit i_len-1 is sent first.
REQ-010 o_vec_csb, o_vec_sclk, o_vec_mosi  out  1 each  vector SPI port.
REQ-011 o_reg_csb, o_reg_sclk, o_reg_mosi  out  1 each  register SPI port.
REQ-012 o_busy  out  1  transaction in progress (not IDLE).
REQ-013 o_done  out  1  one-cycle pulse on the cycle CSB deasserts.

Function
REQ-014 All outputs shall be registered; no combinational path from inputs to outputs.
REQ-015 Handshake: a request shall be accepted on a rising edge where i_valid=1 and o_ready=1; i_target, i_len and i_data are captured on that edge only.
REQ-016 o_ready shall be 1 only in IDLE; i_valid outside IDLE shall be ignored.
REQ-017 Capture rules:
- N = (i_len==0) ? 64 : i_len.
- Shift register loads i_data << (64-N), so the MSB holds the first bit.
REQ-018 State machine: IDLE -> SETUP -> SHIFT_HI <-> SHIFT_LO -> HOLD -> GAP -> IDLE.
REQ-019 SETUP, HALF_DIV cycles:
- selected CSB=0, SCLK=0, MOSI=first bit.
REQ-020 SHIFT_HI, HALF_DIV cycles:
- selected SCLK=1; MOSI stable (peripheral samples on the rising edge).
REQ-021 SHIFT_LO, HALF_DIV cycles, entered only when bits remain:
- SCLK=0; MOSI updates to the next bit on entry.
REQ-022 After the Nth SHIFT_HI the FSM shall enter HOLD, HALF_DIV cycles:
- SCLK=0, CSB=0, MOSI holds the last bit.
REQ-023 Exit from HOLD:
- CSB returns to 1 and o_done pulses for exactly one cycle.
- GAP then runs GAP cycles with CSB=1, SCLK=0, MOSI=0.
- The FSM returns to IDLE.
REQ-024 Transaction timing:
- CSB low for exactly HALF_DIV*(2N+1) cycles.
- Exactly N SCLK rising edges.
- Accept edge to o_ready=1: HALF_DIV*(2N+1)+GAP+1 cycles.
REQ-025 Non-selected port shall stay idle throughout: CSB=1, SCLK=0, MOSI=0.
REQ-026 Bit and half-period counters shall never wrap:
- bit counter 7 bits, counts N down to 0.
- divider 8 bits, reloads on every state change.
REQ-027 i_valid held high continuously: one transaction per IDLE visit, i.e. back-to-back requests are separated by at least GAP CSB-high cycles.

Reset
REQ-028 i_reset_n=0 sampled on any edge shall force IDLE on that edge:
- o_vec_csb=o_reg_csb=1; all SCLK=0 and MOSI=0.
- o_busy=0, o_done=0, o_ready=0 during reset; o_ready=1 on the first edge with i_reset_n=1.
REQ-029 Reset mid-transaction: CSB shall deassert on the reset edge with no further SCLK edges and no o_done pulse; the aborted request is discarded.

Verification
REQ-030 HALF_DIV=2, GAP=4; target=1, len=16, data=0xA5C3 -> reg_csb low 66 cycles, 16 rises sampling 0xA5C3 MSB-first, vec port idle, o_done once, o_ready after 71 cycles.
REQ-031 target=0, len=0, data=0x0123456789ABCDEF -> 64 rises on the vec port sampling 0x0123456789ABCDEF; reg port idle.
REQ-032 len=1, data=0x...01 -> exactly one rise with MOSI=1; CSB low 6 cycles (HALF_DIV=2).
REQ-033 i_valid held with alternating targets -> two transactions, CSB-high gap of at least 4 cycles, i_data changes while busy ignored.
REQ-034 Reset asserted at the 5th SCLK rise of a 16-bit transfer -> CSB=1 next edge, no further SCLK, no o_done, o_ready=1 one edge after reset release.
